// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with fixed-latency busy window and HI/LO registers
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] C_MULT_LAT = 4'(MULT_LAT);
    localparam logic [3:0] C_DIV_LAT  = 4'(DIV_LAT);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_finish;
    logic        w_write;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_b_zero;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_finish = (r_state == S_RUN) && (r_cnt == 4'd1);

    // Arithmetic works only on the latched operands so mid-run input changes are invisible.
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_b_zero = (r_b == 32'd0);
    assign w_abs_a  = r_a[31] ? (32'd0 - r_a) : r_a;
    assign w_abs_b  = r_b[31] ? (32'd0 - r_b) : r_b;
    assign w_q_mag  = w_b_zero ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_r_mag  = w_b_zero ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_q_u    = w_b_zero ? 32'd0 : (r_a / r_b);
    assign w_r_u    = w_b_zero ? 32'd0 : (r_a % r_b);

    // Magnitude division makes 0x80000000 / -1 wrap naturally to 0x80000000 rem 0.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_write  = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_write  = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_write  = 1'b1;
            end
            OP_DIV: begin
                w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
                w_res_hi = r_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
                w_write  = !w_b_zero;
            end
            OP_DIVU: begin
                w_res_lo = w_q_u;
                w_res_hi = w_r_u;
                w_write  = !w_b_zero;
            end
            default: begin
                w_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start && (w_is_mul || w_is_div)) w_next_state = S_RUN;
            S_RUN:  if (r_cnt == 4'd1) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        HI   = r_hi;
        LO   = r_lo;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_op  <= 4'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_finish && w_write) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (w_accept) begin
            if (w_is_mul || w_is_div) begin
                r_op  <= op;
                r_a   <= A;
                r_b   <= B;
                r_cnt <= w_is_mul ? C_MULT_LAT : C_DIV_LAT;
            end else if (op == OP_MTHI) begin
                r_hi <= A;
            end else if (op == OP_MTLO) begin
                r_lo <= A;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        lat = 0;
        case (o)
            4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; lat = MULT_LAT; end
            4'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; lat = MULT_LAT; end
            4'd3: begin
                if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                lat = DIV_LAT;
            end
            4'd4: begin
                if (b != 32'd0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
                lat = DIV_LAT;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: lat = 0;
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at the first idle negedge afterwards.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        int lat;
        start = 1'b1; op = o; A = a; B = b;
        model(o, a, b, lat);
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom_range(0, 15));
            A     = $urandom;
            B     = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("busy_cycles op%0d", o), 32'(n), 32'(lat));
        check($sformatf("busy_low op%0d", o), {31'd0, busy}, 32'd0);
        check($sformatf("hi op%0d a=%h b=%h", o, a, b), HI, m_hi);
        check($sformatf("lo op%0d a=%h b=%h", o, a, b), LO, m_lo);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(1 + $urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat_unused;
        reset = 1'b0; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b1;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg2x3_hi", HI, 32'hFFFF_FFFF);
        check("mult_neg2x3_lo", LO, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", HI, 32'hFFFF_FFFE);
        check("multu_max_lo", LO, 32'h0000_0001);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_lo", LO, 32'hFFFF_FFFD);
        check("div_m7_2_hi", HI, 32'hFFFF_FFFF);
        run_op(4'd5, 32'h11, 32'd0);
        run_op(4'd6, 32'h22, 32'd0);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd0);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'h0000_0000);

        run_op(4'd1, 32'd1000, 32'hFFFF_FF00);
        run_op(4'd5, 32'h1234, 32'd0);
        check("b2b_mthi_hi", HI, 32'h1234);

        // Abort a DIVU with reset on its fourth busy cycle.
        start = 1'b1; op = 4'd4; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        run_op(4'd1, 32'd7, 32'd6);

        reset = 1'b0; start = 1'b1; op = 4'd5; A = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("rst_prio_hi", HI, 32'd0);
        check("rst_prio_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
            run_op(o, pick_val(), pick_val());
        end

        start = 1'b0;
        model(4'd0, 32'd0, 32'd0, lat_unused);
        repeat (3) @(negedge clk);
        check("idle_hold_hi", HI, m_hi);
        check("idle_hold_lo", LO, m_lo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: MULT_LAT, 5, busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 Parameter: DIV_LAT, 10, busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 Port: start  input  1  qualifies op for one cycle.
REQ-006 Port: op  input  4  operation code; see REQ-009.
REQ-007 Port: A, B  input  32 each  operands (A = rs value, B = rt value).
REQ-008 Port: busy  output  1; HI  output  32; LO  output  32  (all registered).

Function
REQ-009 op encoding SHALL be: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; codes 7-15 are treated as NOP.
REQ-010 Two states SHALL exist: IDLE (busy=0) and RUN (busy=1), plus a 4-bit down-counter cnt.
REQ-011 In IDLE, start=1 with op MULT/MULTU SHALL latch A, B and op, load cnt=MULT_LAT and enter RUN at that edge.
REQ-012 In IDLE, start=1 with op DIV/DIVU SHALL latch A, B and op, load cnt=DIV_LAT and enter RUN at that edge.
REQ-013 In RUN, each edge SHALL decrement cnt; the edge where cnt==1 SHALL write the result to HI/LO and return to IDLE, so busy is high for exactly LAT cycles.
REQ-014 HI/LO results SHALL be first visible in the cycle busy reads 0 again (LAT+1 cycles after the start edge).
REQ-015 MULT: {HI,LO} = signed(A)*signed(B), full 64-bit product; MULTU: same, unsigned.
REQ-016 DIV: LO = signed quotient truncated toward zero, HI = remainder carrying the sign of A; DIVU: unsigned quotient/remainder.
REQ-017 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-018 Divide by zero (B==0, DIV or DIVU) SHALL still run DIV_LAT busy cycles and leave HI and LO unchanged.
REQ-019 In IDLE, start=1 with MTHI SHALL write HI=A at that edge; MTLO SHALL write LO=A; neither asserts busy.
REQ-020 Any start while in RUN, of any op, SHALL be ignored: no state, counter or register change.
REQ-021 Operands and op SHALL be taken only from the latched copies during RUN; changes on A/B/op mid-operation have no effect.
REQ-022 start=1 in the same cycle busy falls (first IDLE cycle) SHALL be accepted normally; results of the previous op are already in HI/LO.
REQ-023 MTHI/MTLO accepted in the first IDLE cycle SHALL overwrite the freshly written result in the named register only.
REQ-024 NOP or start=0 SHALL change nothing.
REQ-025 HI and LO SHALL be register outputs with no combinational path from A, B, op or start.

Reset
REQ-026 reset=0 at a rising edge SHALL force state=IDLE, cnt=0, busy=0, HI=0, LO=0, and clear the latched operands and op.
REQ-027 reset=0 during RUN SHALL abort the operation: no result is written and busy=0 next cycle.
REQ-028 reset has priority over start in the same cycle.

Verification
REQ-029 MULT A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
REQ-030 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Same stimulus with B=0 after MTHI 0x11/MTLO 0x22 -> HI=0x11, LO=0x22 unchanged after 10 busy cycles.
REQ-032 Start MULT, then on busy cycle 2 drive start=1 MTLO A=0x55 and change A/B -> MTLO ignored, product of the original operands written.
REQ-033 Start DIVU, assert reset=0 on busy cycle 4 -> next cycle busy=0, HI=LO=0; a new MULT issued immediately afterwards completes in 5 cycles.
REQ-034 Back-to-back: MULT completes, then MTHI A=0x1234 in the first idle cycle -> HI=0x1234, LO keeps the product.
